// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants for the 19-bit single-cycle CPU.
//   INSTR_W        instruction width
//   OP_*           5-bit major opcodes (Instr[18:14])
//   FAULT_*        pc_sequencer fault codes
package cpu_pkg;

  localparam int INSTR_W = 19;

  localparam logic [4:0] OP_R    = 5'b00000;
  localparam logic [4:0] OP_I    = 5'b00001;
  localparam logic [4:0] OP_S    = 5'b00010;
  localparam logic [4:0] OP_BEQ  = 5'b00011;
  localparam logic [4:0] OP_BNE  = 5'b00100;
  localparam logic [4:0] OP_JMP  = 5'b00101;
  localparam logic [4:0] OP_CALL = 5'b00110;
  localparam logic [4:0] OP_RET  = 5'b00111;

  localparam logic [1:0] FAULT_NONE = 2'b00;
  localparam logic [1:0] FAULT_OVF  = 2'b01;
  localparam logic [1:0] FAULT_UDF  = 2'b10;

endpackage

// File: rtl/return_stack.sv
// return_stack: hardware LIFO of return addresses.
//   clk, rst     clock, synchronous active-high reset (pointer only)
//   push, pop    operations; never asserted together by the sequencer
//   push_data    value pushed
//   top          most recently pushed entry (undefined when empty)
//   count        number of valid entries (0..DEPTH)
//   full, empty  status flags
module return_stack #(
  parameter int DEPTH = 8,
  parameter int W     = 14,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  push_data,
  output logic [W-1:0]  top,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  // Storage is deliberately left out of reset; only the pointer clears.
  logic [W-1:0]  mem_q [DEPTH];
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] wr_idx, rd_idx;

  // DEPTH is a power of two, so the low pointer bits index the array and
  // rd_idx wraps to DEPTH-1 correctly when the stack is full.
  assign wr_idx = cnt_q[PW-1:0];
  assign rd_idx = wr_idx - PW'(1);

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign top   = mem_q[rd_idx];
  assign count = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (push && !full)      cnt_d = cnt_q + CW'(1);
    else if (pop && !empty) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  always_ff @(posedge clk) begin
    if (!rst && push && !full) mem_q[wr_idx] <= push_data;
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter and next-PC logic for the single-cycle CPU.
//   clk, rst      clock, synchronous active-high reset
//   stall         freeze PC/stack/state this cycle
//   opcode, imm   fields of the current instruction
//   rs_equal      branch comparison result from the datapath
//   pc            registered PC, addresses instruction memory
//   pc_plus1      pc + 1 (combinational)
//   fault         sticky fault flag (exit only through rst)
//   fault_code    00 none, 01 stack overflow, 10 stack underflow
//   stack_count   valid return-stack entries
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int ADDR_W      = 14,
  parameter int RESET_PC    = 0,
  parameter int STACK_DEPTH = 8,
  localparam int CW         = $clog2(STACK_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic [4:0]        opcode,
  input  logic [13:0]       imm,
  input  logic              rs_equal,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus1,
  output logic              fault,
  output logic [1:0]        fault_code,
  output logic [CW-1:0]     stack_count
);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FAULT = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [1:0]        fc_q, fc_d;

  logic [ADDR_W-1:0] br_off, br_tgt, jmp_tgt, stk_top;
  logic              stk_push, stk_pop, stk_full, stk_empty;

  assign pc_plus1 = pc_q + ADDR_W'(1);
  // Branch offset is relative to pc+1; sign extension makes wrap below 0 fall out.
  assign br_off   = {{(ADDR_W-8){imm[7]}}, imm[7:0]};
  assign br_tgt   = pc_plus1 + br_off;

  if (ADDR_W > 14) begin : g_jmp_zext
    assign jmp_tgt = {{(ADDR_W-14){1'b0}}, imm};
  end else begin : g_jmp_trunc
    assign jmp_tgt = imm[ADDR_W-1:0];
  end

  return_stack #(.DEPTH(STACK_DEPTH), .W(ADDR_W)) u_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (stk_push),
    .pop       (stk_pop),
    .push_data (pc_plus1),
    .top       (stk_top),
    .count     (stack_count),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  always_comb begin
    pc_d     = pc_q;
    state_d  = state_q;
    fc_d     = fc_q;
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    // Stall wins over everything, including fault detection.
    if (state_q == ST_RUN && !stall) begin
      unique case (opcode)
        OP_BEQ:  pc_d = rs_equal  ? br_tgt : pc_plus1;
        OP_BNE:  pc_d = !rs_equal ? br_tgt : pc_plus1;
        OP_JMP:  pc_d = jmp_tgt;
        OP_CALL: begin
          if (stk_full) begin
            state_d = ST_FAULT;
            fc_d    = FAULT_OVF;
          end else begin
            stk_push = 1'b1;
            pc_d     = jmp_tgt;
          end
        end
        OP_RET: begin
          if (stk_empty) begin
            state_d = ST_FAULT;
            fc_d    = FAULT_UDF;
          end else begin
            stk_pop = 1'b1;
            pc_d    = stk_top;
          end
        end
        default: pc_d = pc_plus1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= ADDR_W'(RESET_PC);
      state_q <= ST_RUN;
      fc_q    <= FAULT_NONE;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
      fc_q    <= fc_d;
    end
  end

  assign pc         = pc_q;
  assign fault      = (state_q == ST_FAULT);
  assign fault_code = fc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  localparam int MASK = 16'h3FFF;

  logic        clk = 1'b0;
  logic        rst, stall, rs_equal;
  logic [4:0]  opcode;
  logic [13:0] imm;
  logic [13:0] pc, pc_plus1;
  logic        fault;
  logic [1:0]  fault_code;
  logic [3:0]  stack_count;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: plain integers and a queue for the return stack.
  int m_pc;
  int m_fault;
  int m_fc;
  int m_stk[$];

  pc_sequencer #(.ADDR_W(14), .RESET_PC(0), .STACK_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .stall(stall), .opcode(opcode), .imm(imm),
    .rs_equal(rs_equal), .pc(pc), .pc_plus1(pc_plus1), .fault(fault),
    .fault_code(fault_code), .stack_count(stack_count)
  );

  always #5 clk = ~clk;

  function automatic int wrap(input int v);
    return ((v % 16384) + 16384) % 16384;
  endfunction

  // Apply one instruction, advance the model, then clock and settle.
  task automatic tick(input logic [4:0] op, input logic [13:0] im, input logic eq,
                      input logic st, input logic r);
    int off;
    opcode = op; imm = im; rs_equal = eq; stall = st; rst = r;
    off = im[7] ? int'(im[7:0]) - 256 : int'(im[7:0]);
    if (r) begin
      m_pc = 0; m_fault = 0; m_fc = 0; m_stk.delete();
    end else if (m_fault == 0 && !st) begin
      case (op)
        5'd3: m_pc = eq  ? wrap(m_pc + 1 + off) : wrap(m_pc + 1);
        5'd4: m_pc = !eq ? wrap(m_pc + 1 + off) : wrap(m_pc + 1);
        5'd5: m_pc = int'(im) & MASK;
        5'd6: if (m_stk.size() == 8) begin m_fault = 1; m_fc = 1; end
              else begin m_stk.push_back(wrap(m_pc + 1)); m_pc = int'(im) & MASK; end
        5'd7: if (m_stk.size() == 0) begin m_fault = 1; m_fc = 2; end
              else m_pc = m_stk.pop_back();
        default: m_pc = wrap(m_pc + 1);
      endcase
    end
    @(posedge clk); #1;
    rst = 1'b0; stall = 1'b0;
  endtask

  task automatic test_reset;
    tick(5'd0, 14'd0, 1'b0, 1'b1, 1'b1);
    n_cmp++; if (pc !== 14'd0) begin n_err++; $display("FAIL reset_pc got %0d want 0", pc); end
    n_cmp++; if (fault !== 1'b0 || fault_code !== 2'b00) begin n_err++; $display("FAIL reset_fault got %b/%b want 0/00", fault, fault_code); end
    n_cmp++; if (stack_count !== 4'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", stack_count); end
    for (int i = 1; i <= 4; i++) begin
      tick(5'd0, 14'(i * 77), 1'b0, 1'b0, 1'b0);
      n_cmp++; if (pc !== 14'(i)) begin n_err++; $display("FAIL seq_pc%0d got %0d want %0d", i, pc, i); end
    end
    n_cmp++; if (fault !== 1'b0 || stack_count !== 4'd0) begin n_err++; $display("FAIL seq_state got f=%b c=%0d want 0/0", fault, stack_count); end
  endtask

  task automatic test_branch;
    tick(5'd5, 14'd10, 1'b0, 1'b0, 1'b0);
    tick(5'd3, 14'h00FB, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (pc !== 14'd6) begin n_err++; $display("FAIL beq_taken got %0d want 6", pc); end
    tick(5'd5, 14'd10, 1'b0, 1'b0, 1'b0);
    tick(5'd3, 14'h00FB, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (pc !== 14'd11) begin n_err++; $display("FAIL beq_not got %0d want 11", pc); end
    tick(5'd5, 14'd10, 1'b0, 1'b0, 1'b0);
    tick(5'd4, 14'h00FB, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (pc !== 14'd6) begin n_err++; $display("FAIL bne_taken got %0d want 6", pc); end
    tick(5'd5, 14'd10, 1'b0, 1'b0, 1'b0);
    tick(5'd4, 14'h00FB, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (pc !== 14'd11) begin n_err++; $display("FAIL bne_not got %0d want 11", pc); end
    tick(5'd3, 14'h007F, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (pc !== 14'd139) begin n_err++; $display("FAIL beq_max got %0d want 139", pc); end
  endtask

  task automatic test_call_ret;
    tick(5'd5, 14'd5, 1'b0, 1'b0, 1'b0);
    tick(5'd6, 14'h0100, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (pc !== 14'h100 || stack_count !== 4'd1) begin n_err++; $display("FAIL call got pc=%h c=%0d want 100/1", pc, stack_count); end
    tick(5'd1, 14'd0, 1'b0, 1'b0, 1'b0);
    tick(5'd7, 14'h2222, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (pc !== 14'd6 || stack_count !== 4'd0) begin n_err++; $display("FAIL ret got pc=%0d c=%0d want 6/0", pc, stack_count); end
  endtask

  task automatic test_overflow;
    tick(5'd0, 14'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 8; i++) tick(5'd6, 14'(i * 16), 1'b0, 1'b0, 1'b0);
    n_cmp++; if (pc !== 14'd128 || stack_count !== 4'd8 || fault !== 1'b0) begin n_err++; $display("FAIL call8 got pc=%0d c=%0d f=%b want 128/8/0", pc, stack_count, fault); end
    tick(5'd6, 14'h0200, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (pc !== 14'd128 || fault !== 1'b1 || fault_code !== 2'b01 || stack_count !== 4'd8) begin n_err++; $display("FAIL ovf got pc=%0d f=%b fc=%b c=%0d want 128/1/01/8", pc, fault, fault_code, stack_count); end
    tick(5'd5, 14'h0300, 1'b0, 1'b0, 1'b0);
    tick(5'd7, 14'h0000, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (pc !== 14'd128 || fault_code !== 2'b01 || stack_count !== 4'd8) begin n_err++; $display("FAIL ovf_hold got pc=%0d fc=%b c=%0d want 128/01/8", pc, fault_code, stack_count); end
    tick(5'd0, 14'd0, 1'b0, 1'b1, 1'b1);
    n_cmp++; if (pc !== 14'd0 || fault !== 1'b0 || fault_code !== 2'b00 || stack_count !== 4'd0) begin n_err++; $display("FAIL ovf_reset got pc=%0d f=%b fc=%b c=%0d want 0/0/00/0", pc, fault, fault_code, stack_count); end
  endtask

  task automatic test_underflow_stall;
    tick(5'd5, 14'h0020, 1'b0, 1'b0, 1'b0);
    tick(5'd6, 14'h0300, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (pc !== 14'h20 || stack_count !== 4'd0 || fault !== 1'b0) begin n_err++; $display("FAIL stall_call got pc=%h c=%0d f=%b want 20/0/0", pc, stack_count, fault); end
    tick(5'd7, 14'h0000, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (pc !== 14'h20 || fault !== 1'b0) begin n_err++; $display("FAIL stall_ret got pc=%h f=%b want 20/0", pc, fault); end
    tick(5'd7, 14'h0000, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (pc !== 14'h20 || fault !== 1'b1 || fault_code !== 2'b10) begin n_err++; $display("FAIL udf got pc=%h f=%b fc=%b want 20/1/10", pc, fault, fault_code); end
    tick(5'd0, 14'd0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_wrap;
    tick(5'd5, 14'h3FFF, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (pc_plus1 !== 14'h0000) begin n_err++; $display("FAIL pc_plus1_wrap got %h want 0000", pc_plus1); end
    tick(5'd0, 14'd0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (pc !== 14'h0000) begin n_err++; $display("FAIL pc_wrap got %h want 0000", pc); end
    tick(5'd5, 14'd2, 1'b0, 1'b0, 1'b0);
    tick(5'd3, 14'h00FB, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (pc !== 14'h3FFE) begin n_err++; $display("FAIL neg_wrap got %h want 3FFE", pc); end
  endtask

  task automatic test_random;
    logic [4:0] op;
    tick(5'd0, 14'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 600; i++) begin
      // Bias toward CALL/RET so the stack hits both ends.
      case ($urandom_range(0, 9))
        0, 1:    op = 5'd6;
        2, 3:    op = 5'd7;
        4:       op = 5'd3;
        5:       op = 5'd4;
        6:       op = 5'd5;
        7:       op = 5'($urandom_range(8, 31));
        default: op = 5'($urandom_range(0, 2));
      endcase
      tick(op, 14'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 47) == 0));
      n_cmp++;
      if (pc !== 14'(m_pc) || pc_plus1 !== 14'(wrap(m_pc + 1)) || fault !== 1'(m_fault) ||
          fault_code !== 2'(m_fc) || stack_count !== 4'(m_stk.size())) begin
        n_err++;
        $display("FAIL rand%0d op=%0d got pc=%h p1=%h f=%b fc=%b c=%0d want pc=%h p1=%h f=%0d fc=%0d c=%0d",
                 i, op, pc, pc_plus1, fault, fault_code, stack_count,
                 m_pc, wrap(m_pc + 1), m_fault, m_fc, m_stk.size());
      end
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; opcode = '0; imm = '0; rs_equal = 1'b0;
    m_pc = 0; m_fault = 0; m_fc = 0;
    test_reset;
    test_branch;
    test_call_ret;
    test_overflow;
    test_underflow_stall;
    test_wrap;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
